draw_box: RTL and testbench

- Initiator (logic side) of the screen-request interface; the screen writer is the responder.
- Accepts a box command given as two unordered corners, a colour and a fill flag.
- Issues one screen request covering the box's bounding rectangle, and supplies the per-pixel colour combinationally as the writer sweeps the rectangle.
- In outline mode, interior pixels are written back with old_screen_colour, so they are left unchanged.

---
 rtl/draw_box_if.sv | 29 ++
 rtl/draw_box.sv | 136 +++++++++++++
 tb/tb_draw_box.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/draw_box_if.sv
// Screen-request channel between the box drawer (master) and the screen writer (slave).
// The writer sweeps the requested rectangle and reports each pixel back.
interface draw_box_if #(
   parameter int WIDTH        = 8,
   parameter int COLOUR_WIDTH = 3
);
   logic                    screen_start;
   logic [COLOUR_WIDTH-1:0] new_screen_colour;
   logic [WIDTH-1:0]        screen_x_min;
   logic [WIDTH-1:0]        screen_y_min;
   logic [WIDTH-1:0]        screen_x_range;
   logic [WIDTH-1:0]        screen_y_range;
   logic [WIDTH-1:0]        screen_x;
   logic [WIDTH-1:0]        screen_y;
   logic [COLOUR_WIDTH-1:0] old_screen_colour;
   logic                    screen_done;

   modport master (
      output screen_start, new_screen_colour,
      output screen_x_min, screen_y_min, screen_x_range, screen_y_range,
      input  screen_x, screen_y, old_screen_colour, screen_done
   );

   modport slave (
      input  screen_start, new_screen_colour,
      input  screen_x_min, screen_y_min, screen_x_range, screen_y_range,
      output screen_x, screen_y, old_screen_colour, screen_done
   );
endinterface

// File: rtl/draw_box.sv
// Box drawer: turns a two-corner box command into one rectangle request for the screen
// writer and colours each swept pixel, leaving interior pixels untouched in outline mode.
module draw_box #(
   parameter int WIDTH        = 8,
   parameter int COLOUR_WIDTH = 3
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [WIDTH-1:0]        x0,
   input  logic [WIDTH-1:0]        y0,
   input  logic [WIDTH-1:0]        x1,
   input  logic [WIDTH-1:0]        y1,
   input  logic [COLOUR_WIDTH-1:0] colour,
   input  logic                    fill,
   input  logic                    draw_en,
   output logic                    ready,
   output logic                    done,
   output logic [2*WIDTH:0]        pixels_drawn,
   draw_box_if.master              scr
);
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_BUSY  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam int PIX_W = 2*WIDTH+1;

   state_t                  state_r;
   state_t                  state_nxt_s;
   logic [WIDTH-1:0]        x_min_r;
   logic [WIDTH-1:0]        y_min_r;
   logic [WIDTH-1:0]        x_range_r;
   logic [WIDTH-1:0]        y_range_r;
   logic [COLOUR_WIDTH-1:0] colour_r;
   logic                    fill_r;
   logic                    ready_r;
   logic                    start_r;
   logic                    done_r;
   logic [PIX_W-1:0]        pixels_r;
   logic                    accept_s;
   logic                    on_s;
   logic [WIDTH-1:0]        x_max_s;
   logic [WIDTH-1:0]        y_max_s;
   logic [COLOUR_WIDTH-1:0] new_colour_s;

   function automatic logic [WIDTH-1:0] min_of(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      return (a < b) ? a : b;
   endfunction

   function automatic logic [WIDTH-1:0] abs_diff(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      return (a < b) ? (b - a) : (a - b);
   endfunction

   assign accept_s = draw_en & (state_r == S_IDLE);

   // Next-state decode
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (draw_en) state_nxt_s = S_START;
            else         state_nxt_s = S_IDLE;
         end
         S_START: state_nxt_s = S_BUSY;
         S_BUSY: begin
            if (scr.screen_done) state_nxt_s = S_DONE;
            else                 state_nxt_s = S_BUSY;
         end
         S_DONE:  state_nxt_s = S_IDLE;
         default: state_nxt_s = S_IDLE;
      endcase
   end

   // State register; handshake outputs are registered from the next state
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= S_IDLE;
         ready_r <= 1'b1;
         start_r <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         ready_r <= (state_nxt_s == S_IDLE);
         start_r <= (state_nxt_s == S_START);
         done_r  <= (state_nxt_s == S_DONE);
      end
   end

   // Command capture and coloured-pixel counter
   always_ff @(posedge clock) begin
      if (reset) begin
         x_min_r   <= {WIDTH{1'b0}};
         y_min_r   <= {WIDTH{1'b0}};
         x_range_r <= {WIDTH{1'b0}};
         y_range_r <= {WIDTH{1'b0}};
         colour_r  <= {COLOUR_WIDTH{1'b0}};
         fill_r    <= 1'b0;
         pixels_r  <= {PIX_W{1'b0}};
      end else if (accept_s) begin
         x_min_r   <= min_of(x0, x1);
         y_min_r   <= min_of(y0, y1);
         x_range_r <= abs_diff(x0, x1);
         y_range_r <= abs_diff(y0, y1);
         colour_r  <= colour;
         fill_r    <= fill;
         pixels_r  <= {PIX_W{1'b0}};
      end else if ((state_r == S_BUSY) && on_s) begin
         pixels_r  <= pixels_r + {{(PIX_W-1){1'b0}}, 1'b1};
      end else begin
         pixels_r  <= pixels_r;
      end
   end

   // Border test uses WIDTH-bit sums; min+range never wraps
   always_comb begin
      x_max_s = x_min_r + x_range_r;
      y_max_s = y_min_r + y_range_r;
      on_s    = fill_r
              | (scr.screen_x == x_min_r) | (scr.screen_x == x_max_s)
              | (scr.screen_y == y_min_r) | (scr.screen_y == y_max_s);
      if (on_s) new_colour_s = colour_r;
      else      new_colour_s = scr.old_screen_colour;
   end

   assign ready                 = ready_r;
   assign done                  = done_r;
   assign pixels_drawn          = pixels_r;
   assign scr.screen_start      = start_r;
   assign scr.new_screen_colour = new_colour_s;
   assign scr.screen_x_min      = x_min_r;
   assign scr.screen_y_min      = y_min_r;
   assign scr.screen_x_range    = x_range_r;
   assign scr.screen_y_range    = y_range_r;
endmodule

// File: tb/tb_draw_box.sv
// Bench for draw_box: a raster-sweeping writer model plus a queue of expected pixel colours
// filled when each command is issued and drained as the writer visits pixels.
module tb_draw_box;
   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] x0 = 8'd0, y0 = 8'd0, x1 = 8'd0, y1 = 8'd0;
   logic [2:0] colour = 3'd0;
   logic       fill = 1'b0;
   logic       draw_en = 1'b0;
   logic       ready, done;
   logic [16:0] pixels_drawn;

   draw_box_if #(.WIDTH(8), .COLOUR_WIDTH(3)) scr ();

   draw_box #(.WIDTH(8), .COLOUR_WIDTH(3)) dut (
      .clock(clock), .reset(reset),
      .x0(x0), .y0(y0), .x1(x1), .y1(y1),
      .colour(colour), .fill(fill), .draw_en(draw_en),
      .ready(ready), .done(done), .pixels_drawn(pixels_drawn),
      .scr(scr)
   );

   always #5 clock = ~clock;

   int         checks = 0;
   int         errors = 0;
   logic [2:0] q[$];

   // Writer model
   logic       wr_active;
   logic [7:0] wr_x, wr_y;
   logic       idle_done_stub = 1'b0;
   logic       old_mode = 1'b0;
   logic [2:0] old_const = 3'b010;
   logic [7:0] wr_xmax, wr_ymax;

   assign wr_xmax = scr.screen_x_min + scr.screen_x_range;
   assign wr_ymax = scr.screen_y_min + scr.screen_y_range;
   assign scr.screen_x = wr_x;
   assign scr.screen_y = wr_y;
   assign scr.screen_done = wr_active ? ((wr_x == wr_xmax) && (wr_y == wr_ymax)) : idle_done_stub;
   assign scr.old_screen_colour = old_mode ? (wr_x[2:0] ^ wr_y[2:0]) : old_const;

   always @(posedge clock) begin
      if (reset) begin
         wr_active <= 1'b0;
         wr_x <= 8'd0;
         wr_y <= 8'd0;
      end else if (!wr_active) begin
         if (scr.screen_start) begin
            wr_active <= 1'b1;
            wr_x <= scr.screen_x_min;
            wr_y <= scr.screen_y_min;
         end
      end else if (scr.screen_done) begin
         wr_active <= 1'b0;
      end else if (wr_x == wr_xmax) begin
         wr_x <= scr.screen_x_min;
         wr_y <= wr_y + 8'd1;
      end else begin
         wr_x <= wr_x + 8'd1;
      end
   end

   function automatic logic [2:0] old_of(input int xx, input int yy);
      logic [7:0] bx, by;
      bx = xx[7:0];
      by = yy[7:0];
      return old_mode ? (bx[2:0] ^ by[2:0]) : old_const;
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b expected 1", ready); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
      checks++; if (scr.screen_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %0b expected 0", scr.screen_start); end
      checks++; if (pixels_drawn !== 17'd0) begin errors++; $display("FAIL reset_pixels: got %0d expected 0", pixels_drawn); end
      checks++;
      if ({scr.screen_x_min, scr.screen_y_min, scr.screen_x_range, scr.screen_y_range} !== 32'd0) begin
         errors++; $display("FAIL reset_minrange: got %0h expected 0",
                            {scr.screen_x_min, scr.screen_y_min, scr.screen_x_range, scr.screen_y_range});
      end
      reset = 1'b0;
   endtask

   task automatic run_box(input logic [7:0] ax0, input logic [7:0] ay0, input logic [7:0] ax1,
                          input logic [7:0] ay1, input logic [2:0] col, input logic fl, input logic stub);
      logic [7:0] exmin, eymin, exr, eyr;
      logic [2:0] expc;
      int npix, non, starts;
      bit got_done;
      exmin = (ax0 < ax1) ? ax0 : ax1;
      eymin = (ay0 < ay1) ? ay0 : ay1;
      exr   = (ax0 < ax1) ? (ax1 - ax0) : (ax0 - ax1);
      eyr   = (ay0 < ay1) ? (ay1 - ay0) : (ay0 - ay1);
      npix = 0; non = 0;
      for (int yy = int'(eymin); yy <= int'(eymin) + int'(eyr); yy++) begin
         for (int xx = int'(exmin); xx <= int'(exmin) + int'(exr); xx++) begin
            bit on;
            on = fl || xx == int'(exmin) || xx == int'(exmin) + int'(exr)
                    || yy == int'(eymin) || yy == int'(eymin) + int'(eyr);
            q.push_back(on ? col : old_of(xx, yy));
            npix++;
            if (on) non++;
         end
      end
      @(negedge clock);
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL ready_before_cmd: got %0b expected 1", ready); end
      x0 = ax0; y0 = ay0; x1 = ax1; y1 = ay1; colour = col; fill = fl; draw_en = 1'b1;
      idle_done_stub = stub;
      @(posedge clock);
      #1 draw_en = 1'b0;
      starts = 0; got_done = 0;
      for (int c = 1; c <= npix + 10 && !got_done; c++) begin
         @(negedge clock);
         if (scr.screen_start === 1'b1) begin
            starts++;
            checks++; if (c != 1) begin errors++; $display("FAIL start_cycle: got %0d expected 1", c); end
         end
         if (c == 1 || done === 1'b1) begin
            checks++;
            if ({scr.screen_x_min, scr.screen_y_min, scr.screen_x_range, scr.screen_y_range} !== {exmin, eymin, exr, eyr}) begin
               errors++; $display("FAIL min_range: got %0h expected %0h",
                  {scr.screen_x_min, scr.screen_y_min, scr.screen_x_range, scr.screen_y_range}, {exmin, eymin, exr, eyr});
            end
         end
         if (wr_active) begin
            checks++;
            if (q.size() == 0) begin
               errors++; $display("FAIL pixel_extra: got pixel (%0d,%0d) expected none", wr_x, wr_y);
            end else begin
               expc = q.pop_front();
               if (scr.new_screen_colour !== expc) begin
                  errors++; $display("FAIL pixel_colour (%0d,%0d): got %0b expected %0b", wr_x, wr_y, scr.new_screen_colour, expc);
               end
            end
         end
         if (done === 1'b1) begin
            got_done = 1;
            checks++; if (c != npix + 2) begin errors++; $display("FAIL done_cycle: got %0d expected %0d", c, npix + 2); end
         end
      end
      checks++; if (!got_done) begin errors++; $display("FAIL done_timeout: got no done expected done"); end
      checks++; if (starts != 1) begin errors++; $display("FAIL start_count: got %0d expected 1", starts); end
      checks++; if (q.size() != 0) begin errors++; $display("FAIL pixels_missing: got %0d left expected 0", q.size()); end
      checks++; if (pixels_drawn !== 17'(non)) begin errors++; $display("FAIL pixels_drawn: got %0d expected %0d", pixels_drawn, non); end
      q.delete();
      @(negedge clock);
      idle_done_stub = 1'b0;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_width: got %0b expected 0", done); end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL ready_after: got %0b expected 1", ready); end
      checks++; if (pixels_drawn !== 17'(non)) begin errors++; $display("FAIL pixels_hold: got %0d expected %0d", pixels_drawn, non); end
   endtask

   task automatic test_fill();
      old_mode = 1'b0; old_const = 3'b010;
      run_box(8'd10, 8'd20, 8'd13, 8'd22, 3'b101, 1'b1, 1'b0);
   endtask

   task automatic test_outline();
      old_mode = 1'b0; old_const = 3'b010;
      run_box(8'd10, 8'd20, 8'd13, 8'd22, 3'b101, 1'b0, 1'b0);
   endtask

   task automatic test_reversed();
      old_mode = 1'b1;
      run_box(8'd50, 8'd40, 8'd45, 8'd30, 3'b110, 1'b1, 1'b0);
   endtask

   task automatic test_single_pixel();
      old_mode = 1'b0; old_const = 3'b001;
      run_box(8'd7, 8'd7, 8'd7, 8'd7, 3'b111, 1'b0, 1'b1);
   endtask

   task automatic test_full_extent();
      old_mode = 1'b1;
      run_box(8'd255, 8'd0, 8'd0, 8'd255, 3'b100, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      int starts, dones;
      logic [2:0] expc;
      for (int i = 0; i < 4; i++) q.push_back(3'b011);
      @(negedge clock);
      x0 = 8'd5; y0 = 8'd5; x1 = 8'd6; y1 = 8'd5; colour = 3'b011; fill = 1'b0; draw_en = 1'b1;
      @(posedge clock);
      starts = 0; dones = 0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clock);
         if (scr.screen_start === 1'b1) begin
            starts++;
            checks++; if (c != 1 && c != 6) begin errors++; $display("FAIL b2b_start_cycle: got %0d expected 1 or 6", c); end
         end
         if (done === 1'b1) begin
            dones++;
            checks++; if (c != 4 && c != 9) begin errors++; $display("FAIL b2b_done_cycle: got %0d expected 4 or 9", c); end
         end
         if (wr_active) begin
            checks++;
            if (q.size() == 0) begin
               errors++; $display("FAIL b2b_pixel_extra: got pixel expected none");
            end else begin
               expc = q.pop_front();
               if (scr.new_screen_colour !== expc) begin
                  errors++; $display("FAIL b2b_colour: got %0b expected %0b", scr.new_screen_colour, expc);
               end
            end
         end
      end
      draw_en = 1'b0;
      checks++; if (starts != 2) begin errors++; $display("FAIL b2b_starts: got %0d expected 2", starts); end
      checks++; if (dones != 2) begin errors++; $display("FAIL b2b_dones: got %0d expected 2", dones); end
      checks++; if (q.size() != 0) begin errors++; $display("FAIL b2b_missing: got %0d left expected 0", q.size()); end
      checks++; if (pixels_drawn !== 17'd2) begin errors++; $display("FAIL b2b_pixels: got %0d expected 2", pixels_drawn); end
      q.delete();
      @(negedge clock);
      checks++; if (scr.screen_start !== 1'b0) begin errors++; $display("FAIL b2b_no_accept: got %0b expected 0", scr.screen_start); end
   endtask

   task automatic test_reset_mid_busy();
      int stray;
      @(negedge clock);
      x0 = 8'd100; y0 = 8'd100; x1 = 8'd109; y1 = 8'd109; colour = 3'b110; fill = 1'b1; draw_en = 1'b1;
      @(posedge clock);
      #1 draw_en = 1'b0;
      repeat (4) @(negedge clock);
      checks++; if (pixels_drawn === 17'd0) begin errors++; $display("FAIL midrst_progress: got 0 expected nonzero"); end
      reset = 1'b1;
      @(negedge clock);
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %0b expected 1", ready); end
      checks++; if (scr.screen_start !== 1'b0) begin errors++; $display("FAIL midrst_start: got %0b expected 0", scr.screen_start); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %0b expected 0", done); end
      checks++; if (pixels_drawn !== 17'd0) begin errors++; $display("FAIL midrst_pixels: got %0d expected 0", pixels_drawn); end
      reset = 1'b0;
      stray = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clock);
         if (done === 1'b1 || scr.screen_start === 1'b1) stray++;
      end
      checks++; if (stray != 0) begin errors++; $display("FAIL midrst_stray: got %0d pulses expected 0", stray); end
      old_mode = 1'b0; old_const = 3'b000;
      run_box(8'd3, 8'd9, 8'd0, 8'd6, 3'b010, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_fill();
      test_outline();
      test_reversed();
      test_single_pixel();
      test_full_extent();
      test_back_to_back();
      test_reset_mid_busy();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
